// File: rtl/piso_rr_scheduler_if.sv
// Requester handshake and serial-link signals of the round-robin PISO scheduler.
// The producer side takes the master modport and the scheduler takes the slave modport.
interface piso_rr_scheduler_if #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       Req_Valid;
   logic [NREQ*WIDTH-1:0] Req_Data;
   logic [NREQ-1:0]       Req_Ready;
   logic                  Serial_Out;
   logic                  Valid_O;
   logic                  Frame_Start;
   logic [IDW-1:0]        Grant_Id;
   logic                  Busy;

   modport master (
      output Req_Valid,
      output Req_Data,
      input  Req_Ready,
      input  Serial_Out,
      input  Valid_O,
      input  Frame_Start,
      input  Grant_Id,
      input  Busy
   );

   modport slave (
      input  Req_Valid,
      input  Req_Data,
      output Req_Ready,
      output Serial_Out,
      output Valid_O,
      output Frame_Start,
      output Grant_Id,
      output Busy
   );
endinterface

// File: rtl/piso_rr_scheduler.sv
// Round-robin arbiter in front of one shared serializer: grants a requester in IDLE,
// shifts its word out MSB-first in SHIFT, then idles one GAP cycle before re-arbitrating.
module piso_rr_scheduler #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
) (
   input logic                Clk,
   input logic                Rst,
   piso_rr_scheduler_if.slave bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(WIDTH);

   localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);
   localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q,   ptr_d;
   logic [IDW-1:0]   gid_q,   gid_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;

   logic             win_found_s;
   logic [IDW-1:0]   win_idx_s;
   logic [IDW-1:0]   scan_idx_s;
   logic [NREQ-1:0]  ready_s;
   logic [WIDTH-1:0] win_word_s;

   // Rotating-priority scan: first valid requester at or after ptr_q, wrapping at NREQ.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      scan_idx_s  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx_s = IDW'((int'(ptr_q) + k) % NREQ);
         if (!win_found_s && bus.Req_Valid[scan_idx_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = scan_idx_s;
         end else begin
            win_found_s = win_found_s;
            win_idx_s   = win_idx_s;
         end
      end
   end

   // Grant decode and selection of the winning requester's word.
   always_comb begin
      ready_s    = '0;
      win_word_s = WIDTH'(bus.Req_Data >> (int'(win_idx_s) * WIDTH));
      if ((state_q == ST_IDLE) && win_found_s) begin
         ready_s = NREQ'(1'b1) << win_idx_s;
      end else begin
         ready_s = '0;
      end
   end

   // Next-state logic for the IDLE/SHIFT/GAP sequencer and its datapath.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found_s) begin
               shreg_d = win_word_s;
               gid_d   = win_idx_s;
               cnt_d   = CNT_TOP;
               ptr_d   = (win_idx_s == ID_LAST) ? '0 : (win_idx_s + 1'b1);
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               cnt_d   = cnt_q - 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset discards any partially shifted word.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.Req_Ready   = ready_s;
   assign bus.Serial_Out  = (state_q == ST_SHIFT) & shreg_q[WIDTH-1];
   assign bus.Valid_O     = (state_q == ST_SHIFT);
   assign bus.Frame_Start = (state_q == ST_SHIFT) && (cnt_q == CNT_TOP);
   assign bus.Grant_Id    = gid_q;
   assign bus.Busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Bench for piso_rr_scheduler: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the expected serial schedule.
module tb_piso_rr_scheduler;
   localparam int WIDTH = 4;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   piso_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();
   piso_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (.Clk(clk), .Rst(rst), .bus(bus));

   // One expected output cycle of the serial link.
   typedef struct packed {
      logic           busy;
      logic           vld;
      logic           sbit;
      logic           fs;
      logic [IDW-1:0] gid;
   } exp_t;

   exp_t cur;
   exp_t expq[$];
   int   m_ptr;
   int   m_gid;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [NREQ-1:0]       v_valid;
   logic [NREQ-1:0]       drop_mask;
   logic [NREQ*WIDTH-1:0] v_data;
   logic                  v_rst;

   logic [63:0] obs_stream;
   int          obs_bits;
   int          obs_gq[$];
   int          obs_gcyc[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [31:0] pack_grants();
      logic [31:0] p;
      p = 32'd0;
      foreach (obs_gq[i]) p = (p << 4) | 32'(obs_gq[i]);
      return p;
   endfunction

   task automatic clear_obs();
      obs_stream = 64'd0;
      obs_bits   = 0;
      obs_gq.delete();
      obs_gcyc.delete();
   endtask

   // Apply inputs, compare this cycle's outputs to the model, then advance the model over the edge.
   task automatic cycle();
      int              w;
      logic [WIDTH-1:0] word;
      logic [NREQ-1:0] exp_rdy;
      @(negedge clk);
      rst           = v_rst;
      bus.Req_Valid = v_valid;
      bus.Req_Data  = v_data;
      #1;
      w       = cur.busy ? -1 : rr_pick(v_valid, m_ptr);
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check_eq("req_ready",   32'(bus.Req_Ready),   32'(exp_rdy));
      check_eq("serial_out",  32'(bus.Serial_Out),  32'(cur.sbit));
      check_eq("valid_o",     32'(bus.Valid_O),     32'(cur.vld));
      check_eq("frame_start", 32'(bus.Frame_Start), 32'(cur.fs));
      check_eq("grant_id",    32'(bus.Grant_Id),    32'(cur.gid));
      check_eq("busy",        32'(bus.Busy),        32'(cur.busy));
      if (bus.Valid_O === 1'b1) begin
         obs_stream = {obs_stream[62:0], bus.Serial_Out};
         obs_bits++;
      end
      if (!v_rst) begin
         for (int k = 0; k < NREQ; k++) begin
            if (bus.Req_Ready[k] === 1'b1) begin
               obs_gq.push_back(k);
               obs_gcyc.push_back(cyc);
            end
         end
      end
      if (v_rst) begin
         expq.delete();
         m_ptr = 0;
         m_gid = 0;
      end else if (w >= 0) begin
         word  = v_data[w*WIDTH +: WIDTH];
         m_gid = w;
         m_ptr = (w + 1) % NREQ;
         for (int b = WIDTH - 1; b >= 0; b--) begin
            expq.push_back('{busy: 1'b1, vld: 1'b1, sbit: word[b], fs: (b == WIDTH - 1), gid: IDW'(w)});
         end
         expq.push_back('{busy: 1'b1, vld: 1'b0, sbit: 1'b0, fs: 1'b0, gid: IDW'(w)});
         if (drop_mask[w]) v_valid[w] = 1'b0;
      end
      if (expq.size() > 0) cur = expq.pop_front();
      else cur = '{busy: 1'b0, vld: 1'b0, sbit: 1'b0, fs: 1'b0, gid: IDW'(m_gid)};
      cyc++;
   endtask

   task automatic do_reset();
      v_valid = '0;
      v_rst   = 1'b1;
      cycle();
      v_rst   = 1'b0;
      clear_obs();
   endtask

   task automatic wait_grants(input int n, input int budget);
      int b;
      b = 0;
      while (obs_gq.size() < n && b < budget) begin
         cycle();
         b++;
      end
      check_eq("grant_timeout", 32'(obs_gq.size()), 32'(n));
   endtask

   task automatic drain(input int n);
      repeat (n) cycle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.Req_Valid = '0;
      bus.Req_Data  = '0;
      v_valid       = '0;
      v_data        = '0;
      v_rst         = 1'b0;
      drop_mask     = '1;
      clear_obs();
      repeat (2) @(posedge clk);
      m_ptr = 0;
      m_gid = 0;
      cur   = '{busy: 1'b0, vld: 1'b0, sbit: 1'b0, fs: 1'b0, gid: '0};

      // Single request after reset.
      drain(2);
      check_eq("rst_busy",  32'(bus.Busy),     32'd0);
      check_eq("rst_valid", 32'(bus.Valid_O),  32'd0);
      check_eq("rst_gid",   32'(bus.Grant_Id), 32'd0);
      v_data  = 16'h000C;
      v_valid = 4'b0001;
      wait_grants(1, 10);
      drain(WIDTH + 3);
      check_eq("single_stream", 32'(obs_stream[3:0]), 32'hC);
      check_eq("single_bits",   32'(obs_bits),        32'd4);
      check_eq("single_grant",  pack_grants(),        32'h0);

      // All four requesters held valid.
      do_reset();
      v_data  = 16'h3C9A;
      v_valid = 4'b1111;
      wait_grants(4, 40);
      drain(WIDTH + 3);
      check_eq("all4_stream", 32'(obs_stream[15:0]), 32'hA9C3);
      check_eq("all4_order",  pack_grants(),         32'h0123);
      check_eq("all4_space",  32'(obs_gcyc[3] - obs_gcyc[0]), 32'(3 * (WIDTH + 2)));

      // Fairness: requesters 0 and 2 never release.
      do_reset();
      drop_mask = 4'b0000;
      v_data    = 16'h5A3C;
      v_valid   = 4'b0101;
      wait_grants(4, 40);
      v_valid   = '0;
      drain(WIDTH + 3);
      check_eq("fair_order", pack_grants(), 32'h0202);
      drop_mask = '1;

      // Pointer wrap after a grant to requester 3.
      do_reset();
      v_data  = 16'h7006;
      v_valid = 4'b1000;
      wait_grants(1, 10);
      drain(WIDTH + 1);
      v_valid = 4'b1001;
      wait_grants(3, 30);
      drain(WIDTH + 3);
      check_eq("wrap_order", pack_grants(), 32'h303);

      // Reset in the middle of a frame.
      do_reset();
      v_data  = 16'h0B5A;
      v_valid = 4'b0001;
      wait_grants(1, 10);
      cycle();
      v_rst = 1'b1;
      cycle();
      v_rst   = 1'b0;
      v_valid = 4'b0110;
      cycle();
      check_eq("rmid_valid",  32'(bus.Valid_O),    32'd0);
      check_eq("rmid_serial", 32'(bus.Serial_Out), 32'd0);
      check_eq("rmid_busy",   32'(bus.Busy),       32'd0);
      check_eq("rmid_gid",    32'(bus.Grant_Id),   32'd0);
      check_eq("rmid_ready",  32'(bus.Req_Ready),  32'b0010);
      wait_grants(3, 30);
      drain(WIDTH + 3);
      check_eq("rmid_order", pack_grants(), 32'h012);
      check_eq("rmid_bits",  32'(obs_bits), 32'd10);

      // Request raised while the serializer is busy.
      do_reset();
      v_data  = 16'h0065;
      v_valid = 4'b0001;
      wait_grants(1, 10);
      cycle();
      cycle();
      v_valid[1] = 1'b1;
      wait_grants(2, 20);
      drain(WIDTH + 3);
      check_eq("late_order", pack_grants(), 32'h01);
      check_eq("late_space", 32'(obs_gcyc[1] - obs_gcyc[0]), 32'(WIDTH + 2));

      // Random traffic with occasional resets.
      do_reset();
      repeat (1500) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!v_valid[i]) begin
               if ($urandom_range(3) == 0) begin
                  v_valid[i] = 1'b1;
                  v_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
               end
            end else if ($urandom_range(15) == 0) begin
               v_valid[i] = 1'b0;
            end
         end
         v_rst = ($urandom_range(99) == 0);
         cycle();
      end
      v_rst   = 1'b0;
      v_valid = '0;
      drain(WIDTH + 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
